// File: rtl/m_credit_tracker_pkg.sv
// Feedback-word field positions and credit widths.
// The feedback generator in the input buffer uses the same constants.
package m_credit_tracker_pkg;

    localparam int FEEDBACK_VALID_BIT = 7;
    localparam int FEEDBACK_VC_LSB    = 0;
    localparam int FEEDBACK_VC_MSB    = 2;
    localparam int CREDIT_CNT_WIDTH   = 4;
    localparam int VC_ID_WIDTH        = FEEDBACK_VC_MSB - FEEDBACK_VC_LSB + 1;

    typedef logic [VC_ID_WIDTH-1:0]      vc_id_t;
    typedef logic [CREDIT_CNT_WIDTH-1:0] credit_cnt_t;

    typedef struct packed {
        logic   valid;
        vc_id_t vc;
    } fb_t;

endpackage

// File: rtl/m_credit_tracker_counter.sv
// Saturating per-VC credit counter with single-cycle overflow/underflow pulses.
// A simultaneous inc and dec cancel out, even at either saturation limit.
module m_Credit_Counter
    import m_credit_tracker_pkg::*;
#(
    parameter int P_BUFFER_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        dec_i,
    output credit_cnt_t count_o,
    output logic        ovf_o,
    output logic        unf_o
);

    localparam credit_cnt_t FULL = credit_cnt_t'(P_BUFFER_DEPTH);
    localparam credit_cnt_t ONE  = credit_cnt_t'(1);

    credit_cnt_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == FULL) ovf_o = 1'b1;
            else                 count_d = count_q + ONE;
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) unf_o = 1'b1;
            else               count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= FULL;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/m_credit_tracker.sv
// Output-port credit tracker: registers the returned feedback word, keeps one
// credit counter per downstream VC and flags sticky overflow/underflow.
module m_credit_tracker
    import m_credit_tracker_pkg::*;
#(
    parameter int P_FEEDBACK_WIDTH = 8,
    parameter int P_VC_NUM         = 2,
    parameter int P_BUFFER_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [P_FEEDBACK_WIDTH-1:0]    feedback_in,
    input  logic                           send_valid,
    input  logic [2:0]                     send_vc,
    output logic [P_VC_NUM-1:0]            credit_avail,
    output logic [P_VC_NUM-1:0]            credit_idle,
    output logic [P_VC_NUM*4-1:0]          credit_count,
    output logic                           err_overflow,
    output logic                           err_underflow
);

    localparam credit_cnt_t FULL = credit_cnt_t'(P_BUFFER_DEPTH);

    fb_t  fb_q, fb_d;
    logic err_ovf_q, err_ovf_d;
    logic err_unf_q, err_unf_d;

    logic [P_VC_NUM-1:0] inc, dec, ovf_pulse, unf_pulse;

    // Bits between the VC id and the valid flag carry nothing for this block.
    logic unused_fb_bits;
    assign unused_fb_bits = ^feedback_in[FEEDBACK_VALID_BIT-1:FEEDBACK_VC_MSB+1];

    assign fb_d.valid = feedback_in[FEEDBACK_VALID_BIT];
    assign fb_d.vc    = feedback_in[FEEDBACK_VC_MSB:FEEDBACK_VC_LSB];

    for (genvar v = 0; v < P_VC_NUM; v++) begin : g_vc
        localparam vc_id_t VC_ID = vc_id_t'(v);

        assign inc[v] = fb_q.valid && (fb_q.vc == VC_ID);
        assign dec[v] = send_valid && (send_vc == VC_ID);

        m_Credit_Counter #(
            .P_BUFFER_DEPTH (P_BUFFER_DEPTH)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc[v]),
            .dec_i   (dec[v]),
            .count_o (credit_count[4*v +: 4]),
            .ovf_o   (ovf_pulse[v]),
            .unf_o   (unf_pulse[v])
        );

        assign credit_avail[v] = (credit_count[4*v +: 4] != '0);
        assign credit_idle[v]  = (credit_count[4*v +: 4] == FULL);
    end

    assign err_ovf_d = err_ovf_q | (|ovf_pulse);
    assign err_unf_d = err_unf_q | (|unf_pulse);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_q      <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            fb_q      <= fb_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_m_credit_tracker.sv
// Bench for m_credit_tracker: directed corner cases plus random credit traffic,
// checked every cycle against a behavioural credit model.
module tb_m_credit_tracker;

    localparam int VCN   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] feedback_in = 8'h00;
    logic       send_valid = 1'b0;
    logic [2:0] send_vc = 3'd0;
    logic [VCN-1:0]   credit_avail;
    logic [VCN-1:0]   credit_idle;
    logic [VCN*4-1:0] credit_count;
    logic             err_overflow;
    logic             err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    m_credit_tracker #(
        .P_FEEDBACK_WIDTH (8),
        .P_VC_NUM         (VCN),
        .P_BUFFER_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .feedback_in   (feedback_in),
        .send_valid    (send_valid),
        .send_vc       (send_vc),
        .credit_avail  (credit_avail),
        .credit_idle   (credit_idle),
        .credit_count  (credit_count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: credits held as plain integers, feedback seen one edge late.
    int m_cnt[VCN];
    bit m_fb_valid;
    int m_fb_vc;
    bit m_ovf, m_unf;

    always @(posedge clk or negedge rst_n) begin
        bit is_ret, is_send;
        if (!rst_n) begin
            for (int v = 0; v < VCN; v++) m_cnt[v] = DEPTH;
            m_fb_valid = 0;
            m_fb_vc    = 0;
            m_ovf      = 0;
            m_unf      = 0;
        end else begin
            for (int v = 0; v < VCN; v++) begin
                is_ret  = m_fb_valid && (m_fb_vc == v);
                is_send = send_valid && (int'(send_vc) == v);
                if (is_ret && !is_send) begin
                    if (m_cnt[v] == DEPTH) m_ovf = 1;
                    else m_cnt[v] = m_cnt[v] + 1;
                end else if (is_send && !is_ret) begin
                    if (m_cnt[v] == 0) m_unf = 1;
                    else m_cnt[v] = m_cnt[v] - 1;
                end
            end
            m_fb_valid = feedback_in[7];
            m_fb_vc    = int'(feedback_in[2:0]);
        end
    end

    always @(negedge clk) begin
        logic [VCN*4-1:0] e_cc;
        logic [VCN-1:0]   e_av, e_id;
        for (int v = 0; v < VCN; v++) begin
            e_cc[4*v +: 4] = 4'(m_cnt[v]);
            e_av[v] = (m_cnt[v] != 0);
            e_id[v] = (m_cnt[v] == DEPTH);
        end
        check("model_count", 32'(credit_count), 32'(e_cc));
        check("model_avail", 32'(credit_avail), 32'(e_av));
        check("model_idle",  32'(credit_idle),  32'(e_id));
        check("model_ovf",   32'(err_overflow),  32'(m_ovf));
        check("model_unf",   32'(err_underflow), 32'(m_unf));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int slot_vc[512];

    initial begin
        int t, last, vc;

        #2 rst_n = 1'b0;
        #1;
        check("reset_count", 32'(credit_count), 32'h44);
        check("reset_avail", 32'(credit_avail), 32'h3);
        check("reset_idle",  32'(credit_idle),  32'h3);
        check("reset_errs",  32'({err_overflow, err_underflow}), 32'h0);
        step(2);
        rst_n = 1'b1;

        // Drain VC1 completely
        send_valid = 1'b1; send_vc = 3'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_vc1", 32'(credit_count[7:4]), 32'(3 - i));
        end
        send_valid = 1'b0;
        check("drain_avail1", 32'(credit_avail[1]), 32'h0);

        feedback_in = 8'h81;
        step();
        feedback_in = 8'h00;
        check("fb_not_yet", 32'(credit_count[7:4]), 32'h0);
        step();
        check("fb_latency2", 32'(credit_count[7:4]), 32'h1);

        // Return and send together with VC0 full
        feedback_in = 8'h80;
        step();
        feedback_in = 8'h00; send_valid = 1'b1; send_vc = 3'd0;
        step();
        send_valid = 1'b0;
        check("simul_full_cnt", 32'(credit_count[3:0]), 32'h4);
        check("simul_full_ovf", 32'(err_overflow), 32'h0);

        send_valid = 1'b1; send_vc = 3'd0;
        step(4);
        send_valid = 1'b0;
        check("drain_vc0", 32'(credit_count[3:0]), 32'h0);

        // Return and send together with VC0 empty
        feedback_in = 8'h80;
        step();
        feedback_in = 8'h00; send_valid = 1'b1; send_vc = 3'd0;
        step();
        send_valid = 1'b0;
        check("simul_empty_cnt", 32'(credit_count[3:0]), 32'h0);
        check("simul_empty_unf", 32'(err_underflow), 32'h0);

        send_valid = 1'b1; send_vc = 3'd0;
        step();
        send_valid = 1'b0;
        check("unf_cnt",  32'(credit_count[3:0]), 32'h0);
        check("unf_flag", 32'(err_underflow), 32'h1);

        feedback_in = 8'h05;
        step();
        feedback_in = 8'h00;
        step(2);
        check("ignore_novalid", 32'(credit_count), 32'h10);
        feedback_in = 8'h87;
        step();
        feedback_in = 8'h00;
        step(2);
        check("ignore_vc7", 32'(credit_count), 32'h10);

        feedback_in = 8'h80;
        step(4);
        feedback_in = 8'h81;
        step(3);
        feedback_in = 8'h00;
        step(2);
        check("refill", 32'(credit_count), 32'h44);
        check("refill_ovf", 32'(err_overflow), 32'h0);

        feedback_in = 8'h80;
        step();
        feedback_in = 8'h00;
        step();
        check("ovf_cnt",  32'(credit_count[3:0]), 32'h4);
        check("ovf_flag", 32'(err_overflow), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("ovf_sticky", 32'(err_overflow), 32'h1);
        end

        // Mid-run reset with mixed counts
        send_valid = 1'b1; send_vc = 3'd0;
        step();
        send_vc = 3'd1;
        step(2);
        send_valid = 1'b0;
        check("mixed_before_reset", 32'(credit_count), 32'h23);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_count", 32'(credit_count), 32'h44);
        check("midreset_avail", 32'(credit_avail), 32'h3);
        check("midreset_idle",  32'(credit_idle),  32'h3);
        check("midreset_errs",  32'({err_overflow, err_underflow}), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Random sustained traffic with delayed credit return
        for (int i = 0; i < 512; i++) slot_vc[i] = -1;
        last = 0;
        for (int c = 0; c < 200; c++) begin
            feedback_in = (slot_vc[c] >= 0) ? {5'b10000, 3'(slot_vc[c])} : 8'h00;
            send_valid = 1'b0;
            if ((credit_avail != '0) && ($urandom_range(0, 3) != 0)) begin
                vc = int'($urandom_range(0, VCN - 1));
                if (!credit_avail[vc]) vc = vc ^ 1;
                send_valid = 1'b1;
                send_vc = 3'(vc);
                t = c + int'($urandom_range(1, 6));
                while (slot_vc[t] != -1) t++;
                slot_vc[t] = vc;
                if (t > last) last = t;
            end
            step();
        end
        send_valid = 1'b0;
        for (int c = 200; c <= last; c++) begin
            feedback_in = (slot_vc[c] >= 0) ? {5'b10000, 3'(slot_vc[c])} : 8'h00;
            step();
        end
        feedback_in = 8'h00;
        step(3);
        check("drain_count", 32'(credit_count), 32'h44);
        check("drain_idle",  32'(credit_idle),  32'h3);
        check("drain_errs",  32'({err_overflow, err_underflow}), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
